instr_class_profiler: RTL and testbench

- Multi-lane, parametrised RISC-V instruction-mix profiler. It sits beside the issue stage and classifies up to ISSUE_WIDTH issued instructions per cycle into 13 classes.
- Keeps per-class event counters plus a total-instructions counter and an active-cycles counter.
- Software-visible values come from a snapshot bank through a registered indexed read port.
- Adds sub-features absent from the previous generation: pause without clearing, saturate/wrap mode, and sticky overflow.

---
 rtl/profiler_pkg.sv | 41 ++++
 rtl/instr_classifier.sv | 56 +++++
 rtl/instr_class_profiler.sv | 132 +++++++++++++
 tb/tb_instr_class_profiler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/profiler_pkg.sv
// Shared types and encodings for the instruction-mix profiler.
// Class order doubles as the counter-bank entry index.
package profiler_pkg;

    typedef enum logic [3:0] {
        CL_LOAD    = 4'd0,
        CL_STORE   = 4'd1,
        CL_ADD     = 4'd2,
        CL_SUB     = 4'd3,
        CL_LOGIC   = 4'd4,
        CL_SHIFT   = 4'd5,
        CL_COMPARE = 4'd6,
        CL_BRANCH  = 4'd7,
        CL_JUMP    = 4'd8,
        CL_SYSTEM  = 4'd9,
        CL_ATOMIC  = 4'd10,
        CL_MULDIV  = 4'd11,
        CL_OTHER   = 4'd12
    } instr_class_e;

    localparam int unsigned NUM_CLASSES = 13;
    localparam int unsigned IDX_TOTAL   = 13;
    localparam int unsigned IDX_CYCLES  = 14;
    localparam int unsigned NUM_ENTRIES = 15;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_AMO    = 7'b0101111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/instr_classifier.sv
// Combinational opcode/funct3/funct7 decode of one instruction
// into a profiler class.
module instr_classifier
    import profiler_pkg::*;
(
    input  logic [31:0]  instr_i,
    output instr_class_e class_o
);

    logic [6:0]   opc;
    logic [2:0]   f3;
    logic [6:0]   f7;
    logic         is_op;
    instr_class_e alu_class;

    assign opc   = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign is_op = (opc == OPC_OP);

    // Shared OP / OP-IMM decode; funct7 only matters for register ops.
    always_comb begin
        alu_class = CL_OTHER;
        if (is_op && f7 == F7_MULDIV) begin
            alu_class = CL_MULDIV;
        end else begin
            case (f3)
                3'b000: begin
                    if (!is_op || f7 == F7_BASE) alu_class = CL_ADD;
                    else if (f7 == F7_ALT)       alu_class = CL_SUB;
                    else                         alu_class = CL_OTHER;
                end
                3'b100, 3'b110, 3'b111: alu_class = CL_LOGIC;
                3'b001, 3'b101:         alu_class = CL_SHIFT;
                3'b010, 3'b011:         alu_class = CL_COMPARE;
                default:                alu_class = CL_OTHER;
            endcase
        end
    end

    always_comb begin
        class_o = CL_OTHER;
        unique case (opc)
            OPC_LOAD:           class_o = CL_LOAD;
            OPC_STORE:          class_o = CL_STORE;
            OPC_AUIPC:          class_o = CL_ADD;
            OPC_OP, OPC_OP_IMM: class_o = alu_class;
            OPC_BRANCH:         class_o = CL_BRANCH;
            OPC_JAL, OPC_JALR:  class_o = CL_JUMP;
            OPC_SYSTEM:         class_o = CL_SYSTEM;
            OPC_AMO:            class_o = CL_ATOMIC;
            default:            class_o = CL_OTHER;
        endcase
    end

endmodule

// File: rtl/instr_class_profiler.sv
// Multi-lane instruction-mix profiler: live counter bank, snapshot
// shadow bank and a registered indexed read port.
module instr_class_profiler
    import profiler_pkg::*;
#(
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned CNT_W       = 32,
    parameter bit          SATURATE    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [ISSUE_WIDTH-1:0]   issue_valid,
    input  logic [ISSUE_WIDTH*32-1:0] issue_instr,
    input  logic                     snapshot,
    input  logic                     clear,
    input  logic                     rd_en,
    input  logic [3:0]               rd_idx,
    output logic                     rd_valid,
    output logic [CNT_W-1:0]         rd_data,
    output logic                     rd_ovf,
    output logic                     ovf_any
);

    localparam int unsigned INC_W = $clog2(ISSUE_WIDTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [3:0]  LAST_IDX = 4'(NUM_ENTRIES - 1);

    instr_class_e lane_class [ISSUE_WIDTH];

    for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_lane
        instr_classifier u_cls (
            .instr_i (issue_instr[32*g +: 32]),
            .class_o (lane_class[g])
        );
    end

    logic [INC_W-1:0]       inc      [NUM_ENTRIES];
    logic [CNT_W-1:0]       live_q   [NUM_ENTRIES];
    logic [CNT_W-1:0]       live_d   [NUM_ENTRIES];
    logic [CNT_W-1:0]       shadow_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] ovf_q;
    logic [NUM_ENTRIES-1:0] ovf_d;
    logic [NUM_ENTRIES-1:0] sovf_q;
    logic                   rd_valid_q;
    logic [CNT_W-1:0]       rd_data_q;
    logic                   rd_ovf_q;

    // Per-entry population count of valid lanes.
    always_comb begin
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            inc[e] = '0;
        end
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
            if (issue_valid[l]) begin
                for (int e = 0; e < NUM_CLASSES; e++) begin
                    if (int'(lane_class[l]) == e) begin
                        inc[e] = inc[e] + INC_W'(1);
                    end
                end
                inc[IDX_TOTAL] = inc[IDX_TOTAL] + INC_W'(1);
            end
        end
        inc[IDX_CYCLES] = INC_W'(1);
    end

    always_comb begin
        logic [CNT_W:0] sum;
        sum   = '0;
        ovf_d = ovf_q;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            live_d[e] = live_q[e];
            sum = {1'b0, live_q[e]} + SUM_W'(inc[e]);
            if (clear) begin
                live_d[e] = '0;
                ovf_d[e]  = 1'b0;
            end else if (enable) begin
                if (sum[CNT_W]) begin
                    live_d[e] = SATURATE ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
                    ovf_d[e]  = 1'b1;
                end else begin
                    live_d[e] = sum[CNT_W-1:0];
                end
            end
        end
    end

    // Shadow captures pre-update live state, so snapshot+clear keeps
    // the values being cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                live_q[e]   <= '0;
                shadow_q[e] <= '0;
            end
            ovf_q  <= '0;
            sovf_q <= '0;
        end else begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                live_q[e] <= live_d[e];
                if (snapshot) shadow_q[e] <= live_q[e];
            end
            ovf_q <= ovf_d;
            if (snapshot) sovf_q <= ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ovf_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                if (rd_idx <= LAST_IDX) begin
                    rd_data_q <= shadow_q[rd_idx];
                    rd_ovf_q  <= sovf_q[rd_idx];
                end else begin
                    rd_data_q <= '0;
                    rd_ovf_q  <= 1'b0;
                end
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_ovf   = rd_ovf_q;
    assign ovf_any  = |ovf_q;

endmodule

// File: tb/tb_instr_class_profiler.sv
// Scoreboard bench: a saturating and a wrapping profiler share stimulus;
// expected read results are queued at request time and checked on rd_valid.
module tb_instr_class_profiler;

    localparam int W  = 2;
    localparam int CW = 16;

    localparam logic [31:0] I_ADD  = 32'h00B50533;
    localparam logic [31:0] I_SUB  = 32'h40B50533;
    localparam logic [31:0] I_MUL  = 32'h02B50533;
    localparam logic [31:0] I_LUI  = 32'h000122B7;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_BEQ  = 32'h00B50063;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, enable, snapshot, clear, rd_en;
    logic [3:0]    rd_idx;
    logic [W-1:0]  issue_valid;
    logic [W*32-1:0] issue_instr;
    logic          s_valid, s_ovf, s_any;
    logic          w_valid, w_ovf, w_any;
    logic [CW-1:0] s_data, w_data;

    instr_class_profiler #(.ISSUE_WIDTH(W), .CNT_W(CW), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .enable(enable),
        .issue_valid(issue_valid), .issue_instr(issue_instr),
        .snapshot(snapshot), .clear(clear), .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_valid(s_valid), .rd_data(s_data), .rd_ovf(s_ovf), .ovf_any(s_any)
    );

    instr_class_profiler #(.ISSUE_WIDTH(W), .CNT_W(CW), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .enable(enable),
        .issue_valid(issue_valid), .issue_instr(issue_instr),
        .snapshot(snapshot), .clear(clear), .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_valid(w_valid), .rd_data(w_data), .rd_ovf(w_ovf), .ovf_any(w_any)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [CW:0] exp_s_q [$];
    logic [CW:0] exp_w_q [$];
    logic [CW:0] es, ew;
    logic [3:0]  idx_q [$];
    logic [3:0]  ei;

    always @(negedge clk) begin
        if (s_valid === 1'b1 || w_valid === 1'b1) begin
            vectors++;
            if (exp_s_q.size() == 0 || exp_w_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_read: sat=%0b/%h wrap=%0b/%h with nothing outstanding",
                         s_valid, s_data, w_valid, w_data);
            end else begin
                es = exp_s_q.pop_front();
                ew = exp_w_q.pop_front();
                ei = idx_q.pop_front();
                if ({s_valid, s_ovf, s_data} !== {1'b1, es} ||
                    {w_valid, w_ovf, w_data} !== {1'b1, ew}) begin
                    miscompares++;
                    $display("FAIL read_idx%0d: sat v/ovf/data=%0b/%0b/%h want 1/%0b/%h, wrap=%0b/%0b/%h want 1/%0b/%h",
                             ei, s_valid, s_ovf, s_data, es[CW], es[CW-1:0],
                             w_valid, w_ovf, w_data, ew[CW], ew[CW-1:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [W-1:0] v,
                         input logic [31:0] i0, input logic [31:0] i1);
        enable      = en;
        issue_valid = v;
        issue_instr = {i1, i0};
        step();
    endtask

    task automatic quiet();
        enable      = 1'b0;
        issue_valid = '0;
    endtask

    task automatic snap();
        quiet();
        snapshot = 1'b1;
        step();
        snapshot = 1'b0;
    endtask

    task automatic clr();
        quiet();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic rd_push(input logic [3:0] idx,
                           input logic [CW-1:0] ds, input logic os,
                           input logic [CW-1:0] dw, input logic ow);
        exp_s_q.push_back({os, ds});
        exp_w_q.push_back({ow, dw});
        idx_q.push_back(idx);
        rd_en  = 1'b1;
        rd_idx = idx;
        step();
        rd_en  = 1'b0;
    endtask

    task automatic rd(input logic [3:0] idx, input logic [CW-1:0] d);
        rd_push(idx, d, 1'b0, d, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; snapshot = 1'b0; clear = 1'b0;
        rd_en = 1'b0; rd_idx = '0; issue_valid = '0; issue_instr = '0;
        repeat (3) step();
        vectors++;
        if ({s_valid, s_ovf, s_data, s_any, w_valid, w_ovf, w_data, w_any} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: sat=%0b/%0b/%h/%0b wrap=%0b/%0b/%h/%0b want all 0",
                     s_valid, s_ovf, s_data, s_any, w_valid, w_ovf, w_data, w_any);
        end
        rst = 1'b0;
        rd(4'd0, 16'd0);
        rd(4'd14, 16'd0);
        rd(4'd15, 16'd0);
    endtask

    task automatic test_single_lane();
        drive(1'b1, 2'b01, I_ADD, I_LW);
        drive(1'b1, 2'b01, I_SUB, I_LW);
        drive(1'b1, 2'b01, I_MUL, I_LW);
        drive(1'b1, 2'b01, I_LUI, I_LW);
        snap();
        rd(4'd2, 16'd1);
        rd(4'd3, 16'd1);
        rd(4'd11, 16'd1);
        rd(4'd12, 16'd1);
        rd(4'd13, 16'd4);
        rd(4'd0, 16'd0);
        rd(4'd14, 16'd4);
        clr();
    endtask

    task automatic test_class_sweep();
        logic [31:0] prog [16];
        logic [CW-1:0] want [13];
        prog = '{32'h0000A103, 32'h00A12023, 32'h00150513, 32'h00000517,
                 32'h40B50533, 32'h00B54533, 32'h00151513, 32'h00B52533,
                 32'h00B50063, 32'h0000006F, 32'h000080E7, 32'h00000073,
                 32'h00B5252F, 32'h02B54533, 32'h0000000F, 32'h20B50533};
        want = '{16'd1, 16'd1, 16'd2, 16'd1, 16'd1, 16'd1, 16'd1,
                 16'd1, 16'd2, 16'd1, 16'd1, 16'd1, 16'd2};
        foreach (prog[k]) drive(1'b1, 2'b01, prog[k], I_BEQ);
        snap();
        for (int c = 0; c < 13; c++) rd(4'(c), want[c]);
        rd(4'd13, 16'd16);
        rd(4'd14, 16'd16);
        clr();
    endtask

    task automatic test_dual_lane();
        repeat (5) drive(1'b1, 2'b11, I_LW, I_LW);
        snap();
        rd(4'd0, 16'd10);
        rd(4'd13, 16'd10);
        rd(4'd14, 16'd5);
    endtask

    task automatic test_enable_hold();
        repeat (3) drive(1'b0, 2'b11, I_LW, I_LW);
        repeat (2) drive(1'b1, 2'b11, I_LW, I_LW);
        snap();
        rd(4'd0, 16'd14);
        rd(4'd13, 16'd14);
        rd(4'd14, 16'd7);
    endtask

    task automatic test_snap_clear();
        clr();
        repeat (7) drive(1'b1, 2'b01, I_LW, I_ADD);
        quiet();
        exp_s_q.push_back({1'b0, 16'd14});
        exp_w_q.push_back({1'b0, 16'd14});
        idx_q.push_back(4'd0);
        snapshot = 1'b1; clear = 1'b1; rd_en = 1'b1; rd_idx = 4'd0;
        step();
        snapshot = 1'b0; clear = 1'b0; rd_en = 1'b0;
        rd(4'd0, 16'd7);
        rd(4'd14, 16'd7);
        vectors++;
        if (s_any !== 1'b0 || w_any !== 1'b0) begin
            miscompares++;
            $display("FAIL snapclr_ovf_any: sat=%0b wrap=%0b want 0", s_any, w_any);
        end
        snap();
        rd(4'd0, 16'd0);
        rd(4'd13, 16'd0);
    endtask

    task automatic test_overflow();
        clr();
        repeat (32767) drive(1'b1, 2'b11, I_BEQ, I_BEQ);
        vectors++;
        if (s_any !== 1'b0 || w_any !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_any_at_fffe: sat=%0b wrap=%0b want 0", s_any, w_any);
        end
        drive(1'b1, 2'b11, I_BEQ, I_BEQ);
        vectors++;
        if (s_any !== 1'b1 || w_any !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_any_carry: sat=%0b wrap=%0b want 1", s_any, w_any);
        end
        snap();
        rd_push(4'd7, 16'hFFFF, 1'b1, 16'h0000, 1'b1);
        rd_push(4'd13, 16'hFFFF, 1'b1, 16'h0000, 1'b1);
        rd(4'd14, 16'h8000);
        drive(1'b1, 2'b11, I_BEQ, I_BEQ);
        snap();
        rd_push(4'd7, 16'hFFFF, 1'b1, 16'h0002, 1'b1);
        rd(4'd14, 16'h8001);
        clr();
        vectors++;
        if (s_any !== 1'b0 || w_any !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_any_after_clear: sat=%0b wrap=%0b want 0", s_any, w_any);
        end
        snap();
        rd(4'd7, 16'd0);
    endtask

    task automatic test_reset_mid();
        repeat (3) drive(1'b1, 2'b11, I_LW, I_LW);
        snap();
        rst = 1'b1; rd_en = 1'b1; rd_idx = 4'd0;
        step();
        rst = 1'b0; rd_en = 1'b0;
        vectors++;
        if (s_valid !== 1'b0 || w_valid !== 1'b0 || s_data !== '0 || w_data !== '0) begin
            miscompares++;
            $display("FAIL reset_drops_read: sat=%0b/%h wrap=%0b/%h want 0/0",
                     s_valid, s_data, w_valid, w_data);
        end
        rd(4'd0, 16'd0);
        snap();
        rd(4'd0, 16'd0);
        rd(4'd13, 16'd0);
        rd(4'd14, 16'd0);
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_class_sweep();
        test_dual_lane();
        test_enable_hold();
        test_snap_clear();
        test_overflow();
        test_reset_mid();
        step();
        @(negedge clk);
        vectors++;
        if (exp_s_q.size() != 0 || exp_w_q.size() != 0) begin
            miscompares++;
            $display("FAIL reads_outstanding: sat=%0d wrap=%0d want 0",
                     exp_s_q.size(), exp_w_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
